ex3_to_bcd_serial: RTL and testbench

EX3_TO_BCD_SERIAL -- requirements
Module: ex3_to_bcd_serial

---
 rtl/ex3_to_bcd_serial.sv | 81 ++++++++
 tb/tb_ex3_to_bcd_serial.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex3_to_bcd_serial.sv
// Serial Excess-3 to BCD decoder: shifts in four code bits MSB first and
// presents each decoded digit in a one-entry output slot with valid/ready handshakes.
module ex3_to_bcd_serial #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       bcd,
    output logic             bcd_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slotState_t;

    slotState_t       r_slot;
    logic [3:0]       r_shift;
    logic [1:0]       r_bitCnt;
    logic [3:0]       r_bcd;
    logic             r_bcdErr;
    logic [ERR_W-1:0] r_errCount;

    logic       w_inFire;
    logic       w_outFire;
    logic       w_complete;
    logic [3:0] w_code;
    logic       w_codeValid;

    // Only the 4th bit needs a free slot; the first three may land while a digit waits.
    assign in_ready    = (r_bitCnt != 2'd3) || (r_slot == EMPTY) || out_ready;
    assign w_inFire    = in_valid && in_ready;
    assign w_outFire   = (r_slot == FULL) && out_ready;
    assign w_complete  = w_inFire && (r_bitCnt == 2'd3);
    assign w_code      = {r_shift[2:0], in_bit};
    assign w_codeValid = (w_code >= 4'd3) && (w_code <= 4'd12);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= EMPTY;
            r_shift    <= 4'b0000;
            r_bitCnt   <= 2'd0;
            r_bcd      <= 4'b0000;
            r_bcdErr   <= 1'b0;
            r_errCount <= '0;
        end else begin
            if (w_inFire) begin
                r_shift  <= w_code;
                r_bitCnt <= r_bitCnt + 2'd1;
            end
            // A completing digit wins over a drain so streaming has no bubble.
            if (w_complete) begin
                r_slot <= FULL;
                if (w_codeValid) begin
                    r_bcd    <= w_code - 4'd3;
                    r_bcdErr <= 1'b0;
                end else begin
                    r_bcd    <= 4'b1111;
                    r_bcdErr <= 1'b1;
                    if (r_errCount != {ERR_W{1'b1}}) begin
                        r_errCount <= r_errCount + ERR_W'(1);
                    end
                end
            end else if (w_outFire) begin
                r_slot <= EMPTY;
            end
        end
    end

    assign out_valid = (r_slot == FULL);
    assign bcd       = r_bcd;
    assign bcd_err   = r_bcdErr;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_ex3_to_bcd_serial.sv
// Bench for ex3_to_bcd_serial: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a digit-level behavioural model.
module tb_ex3_to_bcd_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, bcd_err, out_valid;
    logic [3:0] bcd;
    logic [7:0] err_count;

    logic       in_ready2, bcd_err2, out_valid2;
    logic [3:0] bcd2;
    logic [1:0] err_count2;

    int nCompared = 0;
    int nMismatched = 0;
    bit checkEn = 1'b0;

    // Behavioural model: bits collected as an integer, the slot as a held digit.
    int  mBits = 0;
    int  mPartial = 0;
    bit  mFull = 1'b0;
    int  mDigit = 0;
    bit  mErr = 1'b0;
    int  mErrTotal = 0;

    logic [4:0] seen[$];

    always #5 clk = ~clk;

    ex3_to_bcd_serial dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready), .bcd(bcd), .bcd_err(bcd_err),
        .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count)
    );

    ex3_to_bcd_serial #(.ERR_W(2)) dutSmall (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(in_ready2), .bcd(bcd2), .bcd_err(bcd_err2),
        .out_valid(out_valid2), .out_ready(out_ready), .err_count(err_count2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model advances once per rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin
        if (rst) begin
            mBits = 0; mPartial = 0; mFull = 0; mDigit = 0; mErr = 0; mErrTotal = 0;
        end else begin
            bit acceptBit;
            bit drain;
            acceptBit = in_valid && (mBits < 3 || !mFull || out_ready);
            drain = mFull && out_ready;
            if (acceptBit) begin
                mPartial = mPartial * 2 + int'(in_bit);
                mBits++;
            end
            if (mBits == 4) begin
                if (mPartial >= 3 && mPartial <= 12) begin
                    mDigit = mPartial - 3; mErr = 0;
                end else begin
                    mDigit = 15; mErr = 1; mErrTotal++;
                end
                mFull = 1; mBits = 0; mPartial = 0;
            end else if (drain) begin
                mFull = 0;
            end
        end
    end

    // Cycle-by-cycle comparison, sampled mid-cycle after inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (checkEn) begin
            checkOutput("in_ready", in_ready, (mBits < 3 || !mFull || out_ready));
            checkOutput("out_valid", out_valid, mFull);
            if (mFull) begin
                checkOutput("bcd", bcd, mDigit);
                checkOutput("bcd_err", bcd_err, mErr);
            end
            checkOutput("err_count", err_count, (mErrTotal > 255) ? 255 : mErrTotal);
            checkOutput("err_count_w2", err_count2, (mErrTotal > 3) ? 3 : mErrTotal);
            if (out_valid && out_ready && !rst) seen.push_back({bcd_err, bcd});
        end
    end

    task automatic applyStimulus(input logic b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bit = b;
        #2;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (!in_ready) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL bit_accept_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic sendCode(input logic [3:0] code);
        for (int i = 3; i >= 0; i--) applyStimulus(code[i]);
    endtask

    task automatic afterCode(input string name, input logic [4:0] exp);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        checkOutput({name, "_latency_valid"}, out_valid, 1);
        checkOutput({name, "_digit"}, {bcd_err, bcd}, exp);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkNextDigit(input string name, input logic [4:0] exp);
        if (seen.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: no digit transferred, expected %0h", name, exp);
        end else begin
            checkOutput(name, seen.pop_front(), exp);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkEn = 1'b1;
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_bcd", {bcd_err, bcd}, 5'h00);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Two valid codes with a free-running consumer.
        out_ready = 1'b1;
        seen.delete();
        sendCode(4'b0011);
        afterCode("c0011", 5'h00);
        sendCode(4'b1100);
        afterCode("c1100", 5'h09);
        idle(3);
        checkNextDigit("seq_first", 5'h00);
        checkNextDigit("seq_second", 5'h09);

        // All ten valid codes streamed back to back.
        seen.delete();
        for (int d = 0; d < 10; d++) sendCode(4'(d + 3));
        idle(3);
        for (int d = 0; d < 10; d++) checkNextDigit("all_valid", 5'(d));
        checkOutput("all_valid_errs", err_count, 0);

        // Invalid codes; five of them saturate the narrow counter.
        pulseReset();
        seen.delete();
        sendCode(4'b0000);
        sendCode(4'b1101);
        sendCode(4'b1111);
        idle(3);
        checkOutput("invalid_count3", err_count, 3);
        checkNextDigit("inv_0000", 5'h1F);
        checkNextDigit("inv_1101", 5'h1F);
        checkNextDigit("inv_1111", 5'h1F);
        sendCode(4'b0001);
        sendCode(4'b1110);
        idle(3);
        checkOutput("invalid_count5", err_count, 5);
        checkOutput("narrow_saturated", err_count2, 2'b11);

        // Backpressure: next code stalls on its 4th bit, then swaps in with no bubble.
        seen.delete();
        @(negedge clk);
        out_ready = 1'b0;
        sendCode(4'b0100);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_bit = 1'b1;
        #2;
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_held", {out_valid, bcd_err, bcd}, 6'h21);
        @(negedge clk);
        #2;
        checkOutput("stall_in_ready2", in_ready, 0);
        checkOutput("stall_held2", {out_valid, bcd_err, bcd}, 6'h21);
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        checkOutput("release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        checkOutput("swap_no_bubble", {out_valid, bcd_err, bcd}, 6'h22);
        idle(3);
        checkNextDigit("swap_first", 5'h01);
        checkNextDigit("swap_second", 5'h02);

        // Reset mid-code drops the partial bits.
        seen.delete();
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        pulseReset();
        #2;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        sendCode(4'b0110);
        afterCode("c0110", 5'h03);
        idle(3);
        checkNextDigit("midreset_digit", 5'h03);
        checkOutput("midreset_no_extra", seen.size(), 0);
        checkOutput("midreset_errs", err_count, 0);

        // Random traffic with sporadic resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
